// File: rtl/data_sram_responder.sv
// Word-organised CPU data memory with a one-entry store buffer and load forwarding.
// Loads return registered data one cycle after the request.
module data_sram_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        sb_busy,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];

    logic              sb_valid_q, sb_valid_d;
    logic [ADDR_W-1:0] sb_idx_q,   sb_idx_d;
    logic [3:0]        sb_mask_q,  sb_mask_d;
    logic [31:0]       sb_data_q,  sb_data_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic              addr_err_q, addr_err_d;

    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              is_load;
    logic              is_store;
    logic              store_ok;
    logic              hit_idx;
    logic              commit;
    logic [31:0]       load_word;
    logic              unused_addr_bits;

    assign idx              = data_sram_addr[ADDR_W+1:2];
    assign in_range         = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign is_load          = data_sram_en & ~|data_sram_wen;
    assign is_store         = data_sram_en &  |data_sram_wen;
    assign store_ok         = is_store & in_range;
    assign hit_idx          = sb_valid_q & (sb_idx_q == idx);
    assign unused_addr_bits = ^data_sram_addr[1:0];

    // Store buffer next state and the single array write port.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        sb_valid_d = sb_valid_q;
        sb_idx_d   = sb_idx_q;
        sb_mask_d  = sb_mask_q;
        sb_data_d  = sb_data_q;
        commit     = 1'b0;

        if (store_ok) begin
            if (hit_idx) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_sram_wen[b]) begin
                        sb_data_d[8*b +: 8] = data_sram_wdata[8*b +: 8];
                    end
                end
                sb_mask_d = sb_mask_q | data_sram_wen;
            end else begin
                commit     = sb_valid_q;
                sb_valid_d = 1'b1;
                sb_idx_d   = idx;
                sb_mask_d  = data_sram_wen;
                sb_data_d  = data_sram_wdata;
            end
        end else if (sb_valid_q) begin
            commit     = 1'b1;
            sb_valid_d = 1'b0;
        end
    end

    // Load path sees the array before any same-cycle commit, patched by the buffer.
    always_comb begin
        load_word = mem[idx];
        if (hit_idx) begin
            for (int b = 0; b < 4; b++) begin
                if (sb_mask_q[b]) begin
                    load_word[8*b +: 8] = sb_data_q[8*b +: 8];
                end
            end
        end

        rdata_d = rdata_q;
        if (is_load) begin
            rdata_d = in_range ? load_word : 32'h0;
        end

        addr_err_d = addr_err_q | (data_sram_en & ~in_range);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= 1'b0;
            rdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            sb_valid_q <= sb_valid_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Buffer payload is qualified by sb_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        sb_idx_q  <= sb_idx_d;
        sb_mask_q <= sb_mask_d;
        sb_data_q <= sb_data_d;
    end

    // NOTE: the array is deliberately not reset; a store still in the buffer at reset is dropped.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (sb_mask_q[b]) begin
                    mem[sb_idx_q][8*b +: 8] <= sb_data_q[8*b +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign sb_busy         = sb_valid_q;
    assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a visible-memory model predicts rdata,
// sb_busy and addr_err for every cycle; a monitor compares after each rising edge.
module tb_data_sram_responder;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = 4'h0;
    logic [31:0] data_sram_addr = 32'h0;
    logic [31:0] data_sram_wdata = 32'h0;
    logic [31:0] data_sram_rdata;
    logic        sb_busy;
    logic        addr_err;

    always #5 clk = ~clk;

    data_sram_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .sb_busy         (sb_busy),
        .addr_err        (addr_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: mdl_mem is the memory as a load sees it (every store applied at once).
    // The newest store run is remembered with the word it overwrote, so reset can undo it.
    logic [31:0]       mdl_mem [DEPTH];
    logic [31:0]       mdl_rdata = 32'h0;
    logic              mdl_err   = 1'b0;
    logic              pend_valid = 1'b0;
    logic [ADDR_W-1:0] pend_idx   = '0;
    logic [31:0]       pend_backup = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic en, input logic [3:0] wen,
                              input logic [31:0] addr, input logic [31:0] wd);
        logic              ok;
        logic [ADDR_W-1:0] w;
        ok = (addr[31:ADDR_W+2] == '0);
        w  = addr[ADDR_W+1:2];
        if (r) begin
            if (pend_valid) mdl_mem[pend_idx] = pend_backup;
            pend_valid = 1'b0;
            mdl_rdata  = 32'h0;
            mdl_err    = 1'b0;
        end else if (en && wen != 4'h0 && ok) begin
            if (!(pend_valid && pend_idx == w)) begin
                pend_backup = mdl_mem[w];
                pend_idx    = w;
            end
            pend_valid = 1'b1;
            for (int b = 0; b < 4; b++)
                if (wen[b]) mdl_mem[w][8*b +: 8] = wd[8*b +: 8];
        end else begin
            pend_valid = 1'b0;
            if (en) begin
                if (!ok) mdl_err = 1'b1;
                if (wen == 4'h0) mdl_rdata = ok ? mdl_mem[w] : 32'h0;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        rst             = r;
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        model_step(r, en, wen, addr, wd);
        e.rdata = mdl_rdata;
        e.busy  = pend_valid;
        e.err   = mdl_err;
        exp_q.push_back(e);
    endtask

    task automatic st(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd);
        cycle(1'b0, 1'b1, wen, addr, wd);
    endtask

    task automatic ld(input logic [31:0] addr);
        cycle(1'b0, 1'b1, 4'h0, addr, $urandom);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
    endtask

    // Monitor: one expectation per driven cycle, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rdata",    data_sram_rdata,  e.rdata);
            check("sb_busy",  {31'h0, sb_busy},  {31'h0, e.busy});
            check("addr_err", {31'h0, addr_err}, {31'h0, e.err});
        end
    end

    task automatic random_phase(input int n, input bit allow_oor);
        for (int i = 0; i < n; i++) begin
            int unsigned kind;
            logic [31:0] a;
            kind = $urandom_range(0, 99);
            a    = {25'h0, 5'($urandom), 2'($urandom)};
            if (allow_oor && kind < 5) a = 32'h0000_1000 | ($urandom & 32'h000F_FFFF) | (32'($urandom_range(1, 15)) << 28);
            if (kind < 45)      st(a, 4'($urandom_range(1, 15)), $urandom);
            else if (kind < 85) ld(a);
            else                idle();
        end
    endtask

    initial begin
        int guard;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;

        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 4'hF, 32'h10, 32'h5555_5555);

        // Give words 0..31 known contents.
        for (int i = 0; i < 32; i++) st(32'(i * 4), 4'hF, $urandom);
        idle();

        // Store then immediate load: forwarded from the buffer.
        st(32'h10, 4'hF, 32'hDEAD_BEEF);
        ld(32'h10);

        // Byte-lane merge over a known word.
        st(32'h20, 4'hF, 32'h1122_3344);
        idle();
        st(32'h20, 4'h1, 32'h0000_00AA);
        st(32'h20, 4'h4, 32'h00BB_0000);
        ld(32'h20);
        idle();
        ld(32'h20);

        // Back-to-back stores to neighbouring words.
        st(32'h30, 4'hF, 32'hA5A5_0030);
        st(32'h34, 4'hF, 32'h5A5A_0034);
        idle();
        ld(32'h30);
        ld(32'h34);

        // rdata holds across idle cycles with noise on the other inputs.
        ld(32'h10);
        repeat (5) idle();

        random_phase(400, 1'b0);

        // First word past the region: load returns 0, sticky error.
        ld(32'h0000_1000);
        st(32'h08, 4'hF, 32'h0BAD_F00D);
        ld(32'h08);
        st(32'h0000_1004, 4'hF, 32'hFFFF_FFFF);
        ld(32'h04);

        // A store still buffered at reset is lost.
        st(32'h40, 4'hF, 32'h1234_5678);
        idle();
        st(32'h40, 4'hF, 32'hCAFE_F00D);
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        ld(32'h40);

        random_phase(300, 1'b1);
        idle();
        idle();

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
